// File: rtl/draw_executor_if.sv
// ============================================================================
// draw_executor_if
// Start/finished handshake, instruction/result buses and VGA pixel port
// of the draw executor, bundled for the sequencer and adapter side.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface draw_executor_if #(
  parameter int INSTR_W  = 32,
  parameter int RESULT_W = 16,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);
  logic                start;
  logic [INSTR_W-1:0]  instruction;
  logic                finished;
  logic [RESULT_W-1:0] result;
  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;

  modport master (
    output start, instruction,
    input  finished, result, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, instruction,
    output finished, result, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

`default_nettype wire

// File: rtl/draw_executor.sv
// ============================================================================
// draw_executor
// Decodes one packed instruction per rising start edge and issues at most one
// VGA pixel write. Define DRAW_CLIP_EN to suppress writes outside the screen.
// Revision: 1.0
// ============================================================================
`default_nettype none

module draw_executor #(
  parameter int                  INSTR_W  = 32,
  parameter int                  RESULT_W = 16,
  parameter int                  OPCODE_W = 4,
  parameter int                  X_W      = 8,
  parameter int                  Y_W      = 7,
  parameter int                  COLOUR_W = 3,
  parameter int                  SCREEN_W = 160,
  parameter int                  SCREEN_H = 120,
  parameter logic [OPCODE_W-1:0] OP_NOP   = 0,
  parameter logic [OPCODE_W-1:0] OP_DRAW  = 1
) (
  input  logic           clock,
  input  logic           resetn,
  draw_executor_if.slave bus
);

  localparam int c_x_lsb     = OPCODE_W;
  localparam int c_y_lsb     = c_x_lsb + X_W;
  localparam int c_col_lsb   = c_y_lsb + Y_W;
  localparam int c_plot_bit  = c_col_lsb + COLOUR_W;
  localparam int c_payload_w = c_plot_bit + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_PLOT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 state_q;
  logic                   start_q;
  logic [c_payload_w-1:0] instr_q;
  logic                   finished_q;
  logic [2:0]             result_q;
  logic [2:0]             status_q;
  logic [X_W-1:0]         vga_x_q;
  logic [Y_W-1:0]         vga_y_q;
  logic [COLOUR_W-1:0]    vga_colour_q;
  logic                   vga_plot_q;

  logic [OPCODE_W-1:0] w_opcode;
  logic [X_W-1:0]      w_x;
  logic [Y_W-1:0]      w_y;
  logic [COLOUR_W-1:0] w_colour;
  logic                w_plot;
  logic                w_trigger;
  logic                w_is_draw;
  logic                w_clip;
  logic                w_write;
  logic [2:0]          status_d;

  assign w_opcode  = instr_q[OPCODE_W-1:0];
  assign w_x       = instr_q[c_x_lsb +: X_W];
  assign w_y       = instr_q[c_y_lsb +: Y_W];
  assign w_colour  = instr_q[c_col_lsb +: COLOUR_W];
  assign w_plot    = instr_q[c_plot_bit];
  assign w_trigger = bus.start & ~start_q;
  assign w_is_draw = (w_opcode == OP_DRAW);

`ifdef DRAW_CLIP_EN
  localparam logic [X_W:0] c_x_limit = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] c_y_limit = (Y_W+1)'(SCREEN_H);
  assign w_clip = ({1'b0, w_x} >= c_x_limit) || ({1'b0, w_y} >= c_y_limit);
`else
  logic unused_screen;
  assign unused_screen = ^{SCREEN_W, SCREEN_H};
  assign w_clip        = 1'b0;
`endif

  // status bits: [2] clipped, [1] unknown opcode, [0] pixel written
  assign w_write  = w_is_draw & w_plot & ~w_clip;
  assign status_d = {w_is_draw & w_plot & w_clip,
                     ~w_is_draw & (w_opcode != OP_NOP),
                     w_write};

  generate
    if (INSTR_W > c_payload_w) begin : g_unused_hi
      logic unused_instr_hi;
      assign unused_instr_hi = ^bus.instruction[INSTR_W-1:c_payload_w];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b1;
      instr_q      <= '0;
      finished_q   <= 1'b1;
      result_q     <= '0;
      status_q     <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      start_q <= bus.start;
      case (state_q)
        S_IDLE: begin
          if (w_trigger) begin
            instr_q    <= bus.instruction[c_payload_w-1:0];
            finished_q <= 1'b0;
            state_q    <= S_DECODE;
          end
        end
        S_DECODE: begin
          status_q <= status_d;
          if (w_write) begin
            vga_x_q      <= w_x;
            vga_y_q      <= w_y;
            vga_colour_q <= w_colour;
            vga_plot_q   <= 1'b1;
            state_q      <= S_PLOT;
          end else begin
            state_q <= S_DONE;
          end
        end
        S_PLOT: begin
          vga_plot_q <= 1'b0;
          state_q    <= S_DONE;
        end
        S_DONE: begin
          result_q   <= status_q;
          finished_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.finished   = finished_q;
  assign bus.result     = {{(RESULT_W-3){1'b0}}, result_q};
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.vga_plot   = vga_plot_q;

endmodule

`default_nettype wire
